// File: rtl/video_pll_seq_if.sv
// Control/status bundle between the video PLL sequencer (master) and the board side (slave).
// relock_cnt is present only when VIDEO_PLL_SEQ_RELOCK_CNT_EN is defined.
interface video_pll_seq_if;
  logic [1:0] mode_sel;
  logic       mode_req;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       video_rst;
  logic       busy;
  logic       locked;
  logic       fault;
  logic [1:0] cur_mode;
`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
  logic [7:0] relock_cnt;

  modport master (
    input  mode_sel, mode_req, pll_lock,
    output pll_reset, pll_idsel, pll_fbdsel, pll_odsel,
    output video_rst, busy, locked, fault, cur_mode, relock_cnt
  );
  modport slave (
    output mode_sel, mode_req, pll_lock,
    input  pll_reset, pll_idsel, pll_fbdsel, pll_odsel,
    input  video_rst, busy, locked, fault, cur_mode, relock_cnt
  );
`else
  modport master (
    input  mode_sel, mode_req, pll_lock,
    output pll_reset, pll_idsel, pll_fbdsel, pll_odsel,
    output video_rst, busy, locked, fault, cur_mode
  );
  modport slave (
    output mode_sel, mode_req, pll_lock,
    input  pll_reset, pll_idsel, pll_fbdsel, pll_odsel,
    input  video_rst, busy, locked, fault, cur_mode
  );
`endif
endinterface

// File: rtl/video_pll_seq.sv
// rPLL reset/lock sequencer with dynamic divider selects; lock seen 2 cycles late, mode_req dropped while busy.
// Optional lock-loss counter output under VIDEO_PLL_SEQ_RELOCK_CNT_EN.
module video_pll_seq #(
  parameter int          RST_CYCLES    = 16,
  parameter int          LOCK_TIMEOUT  = 27000,
  parameter int          SETTLE_CYCLES = 2700,
  parameter int          LOSS_FILTER   = 4,
  parameter int          MAX_RETRY     = 3,
  parameter logic [1:0]  DEFAULT_MODE  = 2'd0,
  parameter logic [23:0] MODE_IDSEL    = {6'd59, 6'd61, 6'd62, 6'd63},
  parameter logic [23:0] MODE_FBDSEL   = {6'd27, 6'd45, 6'd38, 6'd53},
  parameter logic [23:0] MODE_ODSEL    = {6'd48, 6'd62, 6'd56, 6'd60}
) (
  input logic             clk,
  input logic             rst,
  video_pll_seq_if.master io
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOSS_FILTER + 1);
  localparam int MW = $clog2(MAX_RETRY + 1);

  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SET_LAST   = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_FILTER - 1);
  localparam logic [MW-1:0] RETRY_LAST = MW'(MAX_RETRY - 1);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic          lock_meta;
  logic          lock_s;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] set_cnt;
  logic [LW-1:0] loss_cnt;
  logic [MW-1:0] retry;
  logic [1:0]    cur_mode;
  logic [1:0]    mode_nxt;
  logic [5:0]    idsel_q;
  logic [5:0]    fbdsel_q;
  logic [5:0]    odsel_q;
  logic          loss_hit;
  logic          reset_entry;

  function automatic logic [5:0] pick(input logic [23:0] tbl, input logic [1:0] m);
    return tbl[6*m +: 6];
  endfunction

  assign loss_hit    = !lock_s && (loss_cnt == LOSS_LAST);
  assign reset_entry = (state_nxt == S_RESET_PLL) && (state != S_RESET_PLL);

  // mode_req is checked before lock loss in RUN so a coincident request wins.
  always_comb begin
    state_nxt = state;
    mode_nxt  = cur_mode;
    case (state)
      S_RESET_PLL: if (rst_cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s)                  state_nxt = S_SETTLE;
        else if (to_cnt == TO_LAST)  state_nxt = (retry == RETRY_LAST) ? S_FAULT : S_RESET_PLL;
      end
      S_SETTLE: begin
        if (!lock_s)                 state_nxt = S_WAIT_LOCK;
        else if (set_cnt >= SET_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (io.mode_req) begin
          state_nxt = S_RESET_PLL;
          mode_nxt  = io.mode_sel;
        end else if (loss_hit) begin
          state_nxt = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        if (io.mode_req) begin
          state_nxt = S_RESET_PLL;
          mode_nxt  = io.mode_sel;
        end
      end
      default: state_nxt = S_RESET_PLL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      set_cnt   <= '0;
      loss_cnt  <= '0;
      retry     <= '0;
      cur_mode  <= DEFAULT_MODE;
      idsel_q   <= pick(MODE_IDSEL, DEFAULT_MODE);
      fbdsel_q  <= pick(MODE_FBDSEL, DEFAULT_MODE);
      odsel_q   <= pick(MODE_ODSEL, DEFAULT_MODE);
    end else begin
      lock_meta <= io.pll_lock;
      lock_s    <= lock_meta;
      state     <= state_nxt;
      rst_cnt   <= (state == S_RESET_PLL && state_nxt == S_RESET_PLL) ? rst_cnt + 1'b1 : '0;
      to_cnt    <= (state == S_WAIT_LOCK && state_nxt == S_WAIT_LOCK) ? to_cnt + 1'b1 : '0;
      // The WAIT_LOCK cycle that first sees lock counts as the first settle cycle.
      set_cnt   <= (state_nxt == S_SETTLE) ? set_cnt + 1'b1 : '0;
      loss_cnt  <= (state == S_RUN && state_nxt == S_RUN && !lock_s) ? loss_cnt + 1'b1 : '0;
      if (state == S_WAIT_LOCK && !lock_s && to_cnt == TO_LAST)
        retry <= retry + 1'b1;
      else if (state_nxt == S_RUN || (state == S_FAULT && io.mode_req))
        retry <= '0;
      if (reset_entry) begin
        cur_mode <= mode_nxt;
        idsel_q  <= pick(MODE_IDSEL, mode_nxt);
        fbdsel_q <= pick(MODE_FBDSEL, mode_nxt);
        odsel_q  <= pick(MODE_ODSEL, mode_nxt);
      end
    end
  end

`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
  logic [7:0] relock_q;

  always_ff @(posedge clk) begin
    if (rst)
      relock_q <= 8'h00;
    else if (state == S_RUN && !io.mode_req && loss_hit && relock_q != 8'hFF)
      relock_q <= relock_q + 8'h01;
  end

  assign io.relock_cnt = relock_q;
`endif

  assign io.pll_reset  = (state == S_RESET_PLL);
  assign io.video_rst  = (state != S_RUN);
  assign io.busy       = (state != S_RUN);
  assign io.locked     = (state == S_RUN);
  assign io.fault      = (state == S_FAULT);
  assign io.cur_mode   = cur_mode;
  assign io.pll_idsel  = idsel_q;
  assign io.pll_fbdsel = fbdsel_q;
  assign io.pll_odsel  = odsel_q;
endmodule

// File: tb/tb_video_pll_seq.sv
// Bench for video_pll_seq: timestamp/history model checked every cycle plus directed literal checks.
module tb_video_pll_seq;
  localparam int P_RST = 4, P_TO = 100, P_SET = 8, P_LOSS = 4, P_RETRY = 2;
  localparam int HM = 8191;

  int id_tab [4] = '{63, 62, 61, 59};
  int fb_tab [4] = '{53, 38, 45, 27};
  int od_tab [4] = '{60, 56, 62, 48};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_pll_seq_if bus ();

  video_pll_seq #(
    .RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .SETTLE_CYCLES(P_SET),
    .LOSS_FILTER(P_LOSS), .MAX_RETRY(P_RETRY), .DEFAULT_MODE(2'd0),
    .MODE_IDSEL({6'd59, 6'd61, 6'd62, 6'd63}),
    .MODE_FBDSEL({6'd27, 6'd45, 6'd38, 6'd53}),
    .MODE_ODSEL({6'd48, 6'd62, 6'd56, 6'd60})
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: phase plus entry timestamp; lock decisions read the raw lock history delayed two edges.
  typedef enum int {M_RST, M_WAIT, M_SETTLE, M_RUN, M_FAULT} mph_t;
  mph_t ph = M_RST;
  int   n_edge = 0, t0 = 0, fails = 0, m_mode = 0, m_relock = 0;
  bit   mvalid = 1'b0;
  bit   raw_h [0:HM];
  bit   rst_h [0:HM];

  function automatic bit syn(input int k);
    if (k < 2) return 1'b0;
    return raw_h[(k-2) & HM] && !rst_h[(k-2) & HM] && !rst_h[(k-1) & HM];
  endfunction

  function automatic bit low_window(input int k);
    for (int i = 0; i < P_LOSS; i++)
      if (syn(k - i)) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    n_edge = n_edge + 1;
    raw_h[n_edge & HM] = bus.pll_lock;
    rst_h[n_edge & HM] = rst;
    if (rst) begin
      ph = M_RST; t0 = n_edge; fails = 0; m_mode = 0; m_relock = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      case (ph)
        M_RST: if (n_edge - t0 == P_RST) begin ph = M_WAIT; t0 = n_edge; end
        M_WAIT: begin
          if (syn(n_edge)) begin
            ph = M_SETTLE; t0 = n_edge;
          end else if (n_edge - t0 == P_TO) begin
            fails = fails + 1; t0 = n_edge;
            ph = (fails == P_RETRY) ? M_FAULT : M_RST;
          end
        end
        M_SETTLE: begin
          if (!syn(n_edge)) begin ph = M_WAIT; t0 = n_edge; end
          else if (n_edge - t0 + 1 >= P_SET) begin ph = M_RUN; t0 = n_edge; fails = 0; end
        end
        M_RUN: begin
          if (bus.mode_req) begin
            ph = M_RST; t0 = n_edge; m_mode = int'(bus.mode_sel);
          end else if (n_edge - t0 >= P_LOSS && low_window(n_edge)) begin
            ph = M_RST; t0 = n_edge;
            if (m_relock < 255) m_relock = m_relock + 1;
          end
        end
        M_FAULT: if (bus.mode_req) begin
          ph = M_RST; t0 = n_edge; m_mode = int'(bus.mode_sel); fails = 0;
        end
        default: ph = M_RST;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("status", {25'd0, bus.pll_reset, bus.video_rst, bus.busy, bus.locked, bus.fault, bus.cur_mode},
            {25'd0, ph == M_RST, ph != M_RUN, ph != M_RUN, ph == M_RUN, ph == M_FAULT, 2'(m_mode)});
      check("selects", {14'd0, bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel},
            {14'd0, 6'(id_tab[m_mode]), 6'(fb_tab[m_mode]), 6'(od_tab[m_mode])});
`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
      check("relock_model", {24'd0, bus.relock_cnt}, 32'(m_relock));
`endif
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.pll_reset;
      1:       return bus.video_rst;
      2:       return bus.locked;
      default: return bus.fault;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_lvl(input int sel, input logic val, input int maxc, output int cyc);
    cyc = 0;
    while (sig(sel) !== val && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_sel(input string nm, input int m);
    check(nm, {14'd0, bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel},
          {14'd0, 6'(id_tab[m]), 6'(fb_tab[m]), 6'(od_tab[m])});
  endtask

  task automatic check_reset_vals(input string nm);
    check(nm, {27'd0, bus.pll_reset, bus.video_rst, bus.busy, bus.locked, bus.fault}, 32'h1C);
    check({nm, "_mode"}, {30'd0, bus.cur_mode}, 32'd0);
    check({nm, "_sel"}, {14'd0, bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel},
          {14'd0, 6'd63, 6'd53, 6'd60});
`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
    check({nm, "_relock"}, {24'd0, bus.relock_cnt}, 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.pll_lock = 1'b0;
    bus.mode_req = 1'b0;
    bus.mode_sel = 2'd0;

    // Power-up
    tick(3);
    check_reset_vals("in_reset");
    rst = 1'b0;
    cyc = 0;
    while (bus.pll_reset && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("rst_pulse_len", cyc, 4);
    tick(6);
    bus.pll_lock = 1'b1;
    wait_lvl(2, 1'b1, 50, cyc);
    check("lock_to_run", cyc, 10);
    check("run_video_rst", {31'd0, bus.video_rst}, 0);
    check_sel("run_sel_mode0", 0);

    // Lock loss: short glitch ignored, full filter re-sequences
    bus.pll_lock = 1'b0;
    tick(3);
    bus.pll_lock = 1'b1;
    tick(6);
    check("glitch3_ignored", {31'd0, bus.locked}, 1);
    bus.pll_lock = 1'b0;
    tick(4);
    bus.pll_lock = 1'b1;
    wait_lvl(1, 1'b1, 10, cyc);
    check("loss_detect_delay", cyc, 2);
    check("loss_pll_reset", {31'd0, bus.pll_reset}, 1);
`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
    check("relock_after_loss", {24'd0, bus.relock_cnt}, 1);
`endif
    wait_lvl(2, 1'b1, 60, cyc);
    check("relocked", {31'd0, bus.locked}, 1);

    // Mode change, then a request while busy is dropped
    bus.mode_sel = 2'd1;
    bus.mode_req = 1'b1;
    tick(1);
    bus.mode_req = 1'b0;
    check("mode1_video_rst", {31'd0, bus.video_rst}, 1);
    check("mode1_cur", {30'd0, bus.cur_mode}, 1);
    check("mode1_pll_reset", {31'd0, bus.pll_reset}, 1);
    check_sel("mode1_sel", 1);
`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
    check("relock_mode_req", {24'd0, bus.relock_cnt}, 1);
`endif
    tick(1);
    bus.mode_sel = 2'd3;
    bus.mode_req = 1'b1;
    tick(1);
    bus.mode_req = 1'b0;
    check("busy_req_ignored", {30'd0, bus.cur_mode}, 1);
    wait_lvl(2, 1'b1, 60, cyc);
    check("mode1_run_cur", {30'd0, bus.cur_mode}, 1);

    // mode_req on the same cycle lock loss is detected
    bus.pll_lock = 1'b0;
    tick(5);
    bus.mode_sel = 2'd3;
    bus.mode_req = 1'b1;
    tick(1);
    bus.mode_req = 1'b0;
    bus.pll_lock = 1'b1;
    check("coincident_cur", {30'd0, bus.cur_mode}, 3);
    check_sel("coincident_sel", 3);
`ifdef VIDEO_PLL_SEQ_RELOCK_CNT_EN
    check("coincident_relock", {24'd0, bus.relock_cnt}, 1);
`endif
    wait_lvl(2, 1'b1, 60, cyc);
    check("mode3_run", {31'd0, bus.locked}, 1);

    // Settle glitch restarts the full settle window
    bus.pll_lock = 1'b0;
    bus.mode_sel = 2'd0;
    bus.mode_req = 1'b1;
    tick(1);
    bus.mode_req = 1'b0;
    wait_lvl(0, 1'b0, 20, cyc);
    check("mode0_rst_len", cyc, 4);
    bus.pll_lock = 1'b1;
    tick(6);
    bus.pll_lock = 1'b0;
    tick(3);
    bus.pll_lock = 1'b1;
    check("settle_glitch_not_run", {31'd0, bus.locked}, 0);
    wait_lvl(2, 1'b1, 60, cyc);
    check("settle_restart_len", cyc, 10);

    // Reset asserted during SETTLE
    bus.mode_sel = 2'd2;
    bus.mode_req = 1'b1;
    tick(1);
    bus.mode_req = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);
    check_reset_vals("rst_in_settle");

    // Lock timeout retries into FAULT, then recovery via mode_req
    bus.pll_lock = 1'b0;
    tick(3);
    rst = 1'b0;
    wait_lvl(3, 1'b1, 400, cyc);
    check("fault_time", cyc, 208);
    tick(5);
    check("fault_hold", {29'd0, bus.fault, bus.pll_reset, bus.video_rst}, 32'h5);
    bus.mode_sel = 2'd2;
    bus.mode_req = 1'b1;
    tick(1);
    bus.mode_req = 1'b0;
    check("fault_exit_cur", {30'd0, bus.cur_mode}, 2);
    check("fault_exit_flags", {30'd0, bus.fault, bus.pll_reset}, 32'h1);
    check_sel("fault_exit_sel", 2);
    bus.pll_lock = 1'b1;
    wait_lvl(2, 1'b1, 60, cyc);
    check("fault_recover_run", {31'd0, bus.locked}, 1);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/video_pll_seq.md
Name: video_pll_seq

Overview:
Reset/lock sequencer and dynamic divider controller for the board's Gowin rPLL video clock generator. It runs on the free-running 27 MHz reference clock and performs these jobs:
- drives the PLL RESET pin and the dynamic IDSEL/FBDSEL/ODSEL divider selects;
- watches LOCK and holds the video clock domain in reset until the PLL is stable;
- retries on lock timeout and re-sequences on lock loss or on a requested video-mode change.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_TIMEOUT, 27000, cycles allowed in WAIT_LOCK before the attempt fails
SETTLE_CYCLES, 2700, consecutive cycles of synced lock required before release
LOSS_FILTER, 4, consecutive cycles of synced lock low in RUN that count as lock loss
MAX_RETRY, 3, failed attempts before FAULT
DEFAULT_MODE, 0, mode index used after rst
MODE_IDSEL, 24'h..., four packed 6-bit IDSEL encodings; mode m = bits [6m+5:6m]
MODE_FBDSEL, 24'h..., four packed 6-bit FBDSEL encodings, same packing
MODE_ODSEL, 24'h..., four packed 6-bit ODSEL encodings, same packing

Ports:
clk  in  1  27 MHz reference clock, same net as the PLL clkin
rst  in  1  synchronous, active-high reset
mode_sel  in  2  requested mode index, sampled when mode_req=1
mode_req  in  1  single-cycle mode-change request
pll_lock  in  1  PLL LOCK pin, asynchronous to clk
pll_reset  out  1  to PLL RESET
pll_idsel  out  6  to PLL IDSEL
pll_fbdsel  out  6  to PLL FBDSEL
pll_odsel  out  6  to PLL ODSEL
video_rst  out  1  reset for the video domain, active-high
busy  out  1  high whenever state != RUN
locked  out  1  high only in RUN
fault  out  1  high only in FAULT
cur_mode  out  2  mode index currently applied to the selects

Behaviour:
Clocking and reset:
- Single clock clk. Reset is synchronous and active-high.
- Values while rst=1 and on the first cycle after it: state=RESET_PLL, pll_reset=1, video_rst=1, busy=1, locked=0, fault=0, cur_mode=DEFAULT_MODE, selects = table[DEFAULT_MODE], retry=0, counters=0.

Lock synchronisation:
- pll_lock passes through a 2-flop synchroniser to lock_s. All lock decisions use lock_s, so expect 2 cycles of latency.

Selects:
- Registered. Updated only on entry to RESET_PLL, from the latched mode.
- Therefore stable at least RST_CYCLES cycles before pll_reset falls.

States:
- RESET_PLL: pll_reset=1 and video_rst=1. Count RST_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0.
- WAIT_LOCK: timeout counter increments every cycle.
  - lock_s=1 -> SETTLE.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> retry++.
  - If retry==MAX_RETRY after the increment -> FAULT; otherwise -> RESET_PLL.
- SETTLE: counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK; the settle count clears and the timeout counter restarts.
  - Count reaches SETTLE_CYCLES -> RUN, retry cleared.
- RUN: video_rst=0, locked=1, busy=0.
  - LOSS_FILTER consecutive cycles of lock_s=0 -> RESET_PLL, video_rst=1 on the next cycle. Shorter glitches are ignored and the filter count clears.
- FAULT: pll_reset=0, video_rst=1, fault=1. Held until rst or mode_req.

Mode requests:
- In RUN: latch mode_sel and go to RESET_PLL. video_rst rises on the next cycle and cur_mode updates on the same edge. Requesting the already-current mode still re-sequences.
- In FAULT: latch mode_sel, clear retry, go to RESET_PLL.
- In any other state: ignored (no queueing). The requester must observe busy.

Simultaneous events:
- mode_req and lock-loss detection in the same RUN cycle: the mode request wins (new mode latched). The resulting transition is identical.
- rst during any state overrides everything and returns to the reset values on the next edge.

Counter widths: each counter is sized with $clog2 of its limit+1. No wrap-around is permitted; counters stop at their terminal value.

Optional Feature:
Macro: VIDEO_PLL_SEQ_RELOCK_CNT_EN
- Defined: adds output relock_cnt[7:0]. It increments on every RUN->RESET_PLL transition caused by lock loss (not by mode_req) and saturates at 8'hFF. Cleared only by rst.
- Undefined: port and logic absent; other behaviour identical.

Test Plan:
Common bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=8, LOSS_FILTER=4, MAX_RETRY=2.
1. Power-up: release rst, raise pll_lock 10 cycles later -> pll_reset high exactly 4 cycles. locked=1 and video_rst=0 exactly 2+8 cycles after pll_lock rises; selects = mode 0 table entries throughout.
2. Lock timeout: pll_lock held 0 -> two RESET_PLL pulses of 4 cycles spaced by 100-cycle waits, then fault=1, video_rst=1, pll_reset=0. Then mode_req with mode_sel=2 -> cur_mode=2, new selects, sequence restarts; pll_lock=1 reaches RUN.
3. Settle glitch: pll_lock drops for 3 cycles during SETTLE -> return to WAIT_LOCK; locked only after a full uninterrupted 8-cycle settle.
4. Lock loss in RUN: pll_lock low for 3 cycles -> no change. Low for 4 cycles -> video_rst=1, RESET_PLL re-entered, relock_cnt=1 (macro defined).
5. Mode change: in RUN pulse mode_req with mode_sel=1 -> next cycle video_rst=1, cur_mode=1, selects = mode 1 entries before pll_reset falls; relock_cnt unchanged. mode_req while busy=1 -> ignored.
6. Reset mid-operation: assert rst during SETTLE -> next edge shows all outputs at reset values, cur_mode=DEFAULT_MODE.
